// File: rtl/mux_8x1_rr_sched_pkg.sv
// Shared types and widths for the 8-requester round-robin lane scheduler.
package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] s);
    return N_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux_8x1_rr_sched_pick.sv
// Round-robin search: first set bit of req starting at base, wrapping mod 8.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  always_comb begin
    dbl = {req, req};
    // rot[j] is requester (base + j) mod 8, so bit 0 is the highest priority
    rot = dbl[base +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    found = |req;
    idx   = base + off;
  end

endmodule

// File: rtl/mux_8x1_rr_sched.sv
// Round-robin owner of one 8:1 mux lane: registered grant/select/enable and lane output.
// Handshake: a requester holds req[i] high while it wants the lane; the lane is its
// only while gnt[i]=1, and dropping req[i] releases it at the next clock edge.
module mux_8x1_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             mux_en,
  output logic             y,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  localparam int             HW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0]  HOLD_SAT  = {HW{1'b1}};

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [SEL_W-1:0] sel_d;
  logic             timeout_d;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  rr_pick8 u_pick (
    .req   (req),
    .base  (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    sel_d     = sel;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        // A release in the same cycle as the hold limit counts as a release, not a timeout
        if (!req[sel]) begin
          state_d = GAP;
          ptr_d   = sel + SEL_W'(1);
        end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
          state_d   = GAP;
          ptr_d     = sel + SEL_W'(1);
          timeout_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so there is no req-to-gnt path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      sel     <= '0;
      gnt     <= '0;
      mux_en  <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      y       <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      sel     <= sel_d;
      gnt     <= (state_d == GRANT) ? onehot_sel(sel_d) : '0;
      mux_en  <= (state_d == GRANT);
      busy    <= (state_d != IDLE);
      timeout <= timeout_d;
      y       <= mux_en ? data_in[sel] : 1'b0;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_8x1_rr_sched.sv
// Directed vector table plus corner sequences and a randomized property run for mux_8x1_rr_sched.
module tb_mux_8x1_rr_sched;

  localparam int MAX_HOLD = 4;
  localparam int STARVE_MAX = 7 * (MAX_HOLD + 2) + 2;
  localparam int NV = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, data_in, gnt;
  logic [2:0] sel;
  logic       mux_en, y, busy, timeout;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic [7:0] data;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       en;
    logic       y;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[NV];

  mux_8x1_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .sel       (sel),
    .mux_en    (mux_en),
    .y         (y),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] r, input logic [7:0] d, input logic [7:0] g,
                              input int s, input bit e, input bit yy, input bit b, input bit t);
    vec_t v;
    v.req = r; v.data = d; v.gnt = g; v.sel = 3'(s);
    v.en = e; v.y = yy; v.busy = b; v.to = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] d);
    req     = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         wait_cnt[8];
    int         max_wait[8];
    logic [7:0] r;
    logic [7:0] d;

    // req, data, gnt, sel, en, y, busy, timeout
    // Single persistent requester 0: 4-cycle grant, timeout, GAP, IDLE, re-grant
    tbl[0]  = mk(8'h01, 8'h01, 8'h01, 0, 1, 0, 1, 0);
    tbl[1]  = mk(8'h01, 8'h00, 8'h01, 0, 1, 0, 1, 0);
    tbl[2]  = mk(8'h01, 8'h01, 8'h01, 0, 1, 1, 1, 0);
    tbl[3]  = mk(8'h01, 8'hFE, 8'h01, 0, 1, 0, 1, 0);
    tbl[4]  = mk(8'h01, 8'h01, 8'h00, 0, 0, 1, 1, 1);
    tbl[5]  = mk(8'h01, 8'h01, 8'h00, 0, 0, 0, 0, 0);
    tbl[6]  = mk(8'h01, 8'h01, 8'h01, 0, 1, 0, 1, 0);
    tbl[7]  = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    tbl[8]  = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    // Requesters 0 and 7 alternate, ptr starts at 1
    tbl[9]  = mk(8'h81, 8'h80, 8'h80, 7, 1, 0, 1, 0);
    tbl[10] = mk(8'h81, 8'h80, 8'h80, 7, 1, 1, 1, 0);
    tbl[11] = mk(8'h81, 8'h80, 8'h80, 7, 1, 1, 1, 0);
    tbl[12] = mk(8'h81, 8'h80, 8'h80, 7, 1, 1, 1, 0);
    tbl[13] = mk(8'h81, 8'h80, 8'h00, 0, 0, 1, 1, 1);
    tbl[14] = mk(8'h81, 8'h80, 8'h00, 0, 0, 0, 0, 0);
    tbl[15] = mk(8'h81, 8'h80, 8'h01, 0, 1, 0, 1, 0);
    tbl[16] = mk(8'h81, 8'h80, 8'h01, 0, 1, 0, 1, 0);
    tbl[17] = mk(8'h81, 8'h80, 8'h01, 0, 1, 0, 1, 0);
    tbl[18] = mk(8'h81, 8'h80, 8'h01, 0, 1, 0, 1, 0);
    tbl[19] = mk(8'h81, 8'h80, 8'h00, 0, 0, 0, 1, 1);
    tbl[20] = mk(8'h81, 8'h80, 8'h00, 0, 0, 0, 0, 0);
    tbl[21] = mk(8'h81, 8'h80, 8'h80, 7, 1, 0, 1, 0);
    tbl[22] = mk(8'h00, 8'h80, 8'h00, 0, 0, 1, 1, 0);
    tbl[23] = mk(8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 0);
    // Owner 3 releases on its last hold cycle: release wins, ptr becomes 4
    tbl[24] = mk(8'h08, 8'h08, 8'h08, 3, 1, 0, 1, 0);
    tbl[25] = mk(8'h08, 8'h08, 8'h08, 3, 1, 1, 1, 0);
    tbl[26] = mk(8'h08, 8'h08, 8'h08, 3, 1, 1, 1, 0);
    tbl[27] = mk(8'h08, 8'h08, 8'h08, 3, 1, 1, 1, 0);
    tbl[28] = mk(8'h00, 8'h08, 8'h00, 0, 0, 1, 1, 0);
    tbl[29] = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    tbl[30] = mk(8'h19, 8'h00, 8'h10, 4, 1, 0, 1, 0);
    tbl[31] = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    tbl[32] = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    // Owner 7 releases while 0 and 7 request: ptr wraps to 0
    tbl[33] = mk(8'h80, 8'h00, 8'h80, 7, 1, 0, 1, 0);
    tbl[34] = mk(8'h81, 8'h00, 8'h80, 7, 1, 0, 1, 0);
    tbl[35] = mk(8'h01, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    tbl[36] = mk(8'h81, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    tbl[37] = mk(8'h81, 8'h00, 8'h01, 0, 1, 0, 1, 0);
    tbl[38] = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    tbl[39] = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);

    rst_n   = 1'b0;
    req     = 8'h00;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", gnt, 8'h00);
    chk("reset sel", 8'(sel), 8'h00);
    chk("reset mux_en", 8'(mux_en), 8'h00);
    chk("reset y", 8'(y), 8'h00);
    chk("reset busy", 8'(busy), 8'h00);
    chk("reset timeout", 8'(timeout), 8'h00);
    chk("reset state", 8'(dbg_state), 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].req, tbl[i].data);
      chk($sformatf("v%0d gnt", i), gnt, tbl[i].gnt);
      if (tbl[i].en) chk($sformatf("v%0d sel", i), 8'(sel), 8'(tbl[i].sel));
      chk($sformatf("v%0d mux_en", i), 8'(mux_en), 8'(tbl[i].en));
      chk($sformatf("v%0d y", i), 8'(y), 8'(tbl[i].y));
      chk($sformatf("v%0d busy", i), 8'(busy), 8'(tbl[i].busy));
      chk($sformatf("v%0d timeout", i), 8'(timeout), 8'(tbl[i].to));
    end

    // Asynchronous reset in the middle of a grant to owner 5 (ptr is 1 here)
    step(8'h20, 8'hFF);
    chk("arst pre gnt", gnt, 8'h20);
    chk("arst pre sel", 8'(sel), 8'h05);
    step(8'h20, 8'hFF);
    chk("arst pre y", 8'(y), 8'h01);
    #3 rst_n = 1'b0;
    #1;
    chk("arst gnt", gnt, 8'h00);
    chk("arst sel", 8'(sel), 8'h00);
    chk("arst mux_en", 8'(mux_en), 8'h00);
    chk("arst y", 8'(y), 8'h00);
    chk("arst busy", 8'(busy), 8'h00);
    chk("arst timeout", 8'(timeout), 8'h00);
    req = 8'h03;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(8'h03, 8'h01);
    chk("arst regrant gnt", gnt, 8'h01);
    chk("arst regrant sel", 8'(sel), 8'h00);
    step(8'h00, 8'h00);
    chk("arst gap busy", 8'(busy), 8'h01);
    chk("arst gap gnt", gnt, 8'h00);
    step(8'h00, 8'h00);
    chk("arst idle busy", 8'(busy), 8'h00);
    step(8'h04, 8'h04);
    chk("req2 gnt", gnt, 8'h04);
    chk("req2 sel", 8'(sel), 8'h02);
    step(8'h04, 8'h04);
    chk("req2 y", 8'(y), 8'h01);
    step(8'h00, 8'h00);
    step(8'h00, 8'h00);
    chk("req2 idle busy", 8'(busy), 8'h00);

    // Random sticky requests with property checks
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_cnt[i] = 0;
      max_wait[i] = 0;
    end
    for (int c = 0; c < 1000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(mux_en ? d[sel] : 1'b0);
      step(r, d);
      chk("rnd y", 8'(y), 8'(exp_q.pop_front()));
      chk("rnd onehot0", 8'($onehot0(gnt)), 8'h01);
      if (mux_en) chk("rnd gnt_sel", gnt, 8'h01 << sel);
      for (int i = 0; i < 8; i++) begin
        if (r[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (max_wait[i] > STARVE_MAX) begin
        n_err++;
        $display("FAIL starve req%0d: waited %0d cycles, limit %0d", i, max_wait[i], STARVE_MAX);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
